// File: rtl/c_port_arbiter_pkg.sv
// Shared types for the C-port arbiter: FSM state encoding and default watchdog.
package c_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_DONE
   } Arb_State;

   localparam int ARB_TIMEOUT_DEF = 1023;

endpackage

// File: rtl/c_port_arbiter_if.sv
// Requester-side and bridge-side signals of the shared C port.
// slave: the arbiter's view; master: the view of whatever drives requests
// and models the bridge.
interface c_port_arbiter_if;

   logic        rq0_valid;
   logic [7:0]  rq0_addr;
   logic [63:0] rq0_wdata;
   logic        rq0_r_wb;
   logic        rq0_done;
   logic        rq0_err;
   logic [63:0] rq0_rdata;

   logic        rq1_valid;
   logic [7:0]  rq1_addr;
   logic [63:0] rq1_wdata;
   logic        rq1_r_wb;
   logic        rq1_done;
   logic        rq1_err;
   logic [63:0] rq1_rdata;

   logic        C_in_valid;
   logic [7:0]  C_addr;
   logic [63:0] C_data_w;
   logic        C_r_wb;
   logic        C_out_valid;
   logic [63:0] C_data_r;

   modport slave (
      input  rq0_valid, rq0_addr, rq0_wdata, rq0_r_wb,
      output rq0_done, rq0_err, rq0_rdata,
      input  rq1_valid, rq1_addr, rq1_wdata, rq1_r_wb,
      output rq1_done, rq1_err, rq1_rdata,
      output C_in_valid, C_addr, C_data_w, C_r_wb,
      input  C_out_valid, C_data_r
   );

   modport master (
      output rq0_valid, rq0_addr, rq0_wdata, rq0_r_wb,
      input  rq0_done, rq0_err, rq0_rdata,
      output rq1_valid, rq1_addr, rq1_wdata, rq1_r_wb,
      input  rq1_done, rq1_err, rq1_rdata,
      input  C_in_valid, C_addr, C_data_w, C_r_wb,
      output C_out_valid, C_data_r
   );

endinterface

// File: rtl/c_port_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_id,
   output logic       any
);

   // tie-break against the previous winner, otherwise whoever is asking
   always_comb begin
      any = |req;
      if (&req) gnt_id = ~last_gnt;
      else      gnt_id = req[1];
   end

endmodule

// File: rtl/c_port_arbiter.sv
// Shares one bridge C port between two requesters, one transaction in flight,
// with a watchdog that aborts a transaction the bridge never completes.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ARB_IDLE  | no transaction; pick a winner and latch its command
// ARB_ISSUE | single-cycle C_in_valid pulse to the bridge, watchdog cleared
// ARB_WAIT  | waiting for C_out_valid; watchdog counting toward timeout
// ARB_DONE  | one-cycle done/err pulse to the granted requester
module c_port_arbiter
   import c_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF,
   parameter int CNT_W       = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   c_port_arbiter_if.slave bus,
   output logic            busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   Arb_State         state_q, state_nxt;
   logic             last_gnt_q;
   logic             gnt_q;
   logic [7:0]       addr_q;
   logic [63:0]      wdata_q;
   logic             r_wb_q;
   logic             err_q;
   logic [63:0]      rdata0_q, rdata1_q;
   logic [CNT_W-1:0] cnt_q;

   logic             pick_id, pick_any;
   logic             grant, wait_hit, wait_tmo;

   rr_pick2 u_pick (
      .req      ({bus.rq1_valid, bus.rq0_valid}),
      .last_gnt (last_gnt_q),
      .gnt_id   (pick_id),
      .any      (pick_any)
   );

   // a bridge completion takes priority over a timeout in the same cycle
   assign grant    = (state_q == ARB_IDLE) && pick_any;
   assign wait_hit = (state_q == ARB_WAIT) && bus.C_out_valid;
   assign wait_tmo = (state_q == ARB_WAIT) && !bus.C_out_valid && (cnt_q == CNT_LAST);

   // next-state decode
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ARB_IDLE:  if (pick_any) state_nxt = ARB_ISSUE;
         ARB_ISSUE: state_nxt = ARB_WAIT;
         ARB_WAIT:  if (wait_hit || wait_tmo) state_nxt = ARB_DONE;
         ARB_DONE:  state_nxt = ARB_IDLE;
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ARB_IDLE;
      else        state_q <= state_nxt;
   end

   // grant/command latch, watchdog and per-requester read data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         r_wb_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         cnt_q      <= '0;
      end else begin
         if (grant) begin
            gnt_q      <= pick_id;
            last_gnt_q <= pick_id;
            addr_q     <= pick_id ? bus.rq1_addr  : bus.rq0_addr;
            wdata_q    <= pick_id ? bus.rq1_wdata : bus.rq0_wdata;
            r_wb_q     <= pick_id ? bus.rq1_r_wb  : bus.rq0_r_wb;
         end

         if (state_q == ARB_ISSUE)     cnt_q <= '0;
         else if (state_q == ARB_WAIT) cnt_q <= cnt_q + 1'b1;

         if (wait_hit) begin
            err_q <= 1'b0;
            if (r_wb_q) begin
               if (gnt_q) rdata1_q <= bus.C_data_r;
               else       rdata0_q <= bus.C_data_r;
            end
         end else if (wait_tmo) begin
            err_q <= 1'b1;
            if (gnt_q) rdata1_q <= '0;
            else       rdata0_q <= '0;
         end
      end
   end

   assign bus.C_in_valid = (state_q == ARB_ISSUE);
   assign bus.C_addr     = addr_q;
   assign bus.C_data_w   = wdata_q;
   assign bus.C_r_wb     = r_wb_q;

   assign bus.rq0_done   = (state_q == ARB_DONE) && !gnt_q;
   assign bus.rq1_done   = (state_q == ARB_DONE) &&  gnt_q;
   assign bus.rq0_err    = bus.rq0_done && err_q;
   assign bus.rq1_err    = bus.rq1_done && err_q;
   assign bus.rq0_rdata  = rdata0_q;
   assign bus.rq1_rdata  = rdata1_q;

   assign busy           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_c_port_arbiter.sv
// Bench for c_port_arbiter: a fixed transaction table, back-to-back fairness,
// randomized traffic against a request-level model, and hand-written
// timeout/reset sequences.
module tb_c_port_arbiter;

   localparam int TMO = 1023;

   logic clk;
   logic rst_n;
   logic busy;

   c_port_arbiter_if bus ();

   c_port_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // request-level model of what each requester asked for and should hold
   logic [7:0]  m_addr  [2];
   logic [63:0] m_wdata [2];
   logic        m_rw    [2];
   logic [63:0] m_rdata [2];
   int          m_last;
   logic        pend    [2];

   typedef struct {
      logic        v0, v1;
      logic [7:0]  a0, a1;
      logic [63:0] w0, w1;
      logic        rw0, rw1;
      int          dly;
      logic [63:0] rsp;
      int          exp_id;
   } vec_t;

   vec_t tbl [8];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // lone requester wins; on a tie the one not served last time wins
   function automatic int ref_pick(input logic v0, input logic v1);
      if (v0 && v1) return (m_last == 0) ? 1 : 0;
      return v0 ? 0 : 1;
   endfunction

   task automatic set_req(input int r, input logic [7:0] a, input logic [63:0] w, input logic rw);
      m_addr[r] = a; m_wdata[r] = w; m_rw[r] = rw;
      if (r == 0) begin bus.rq0_addr = a; bus.rq0_wdata = w; bus.rq0_r_wb = rw; end
      else        begin bus.rq1_addr = a; bus.rq1_wdata = w; bus.rq1_r_wb = rw; end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},     64'(busy), 64'd0);
      chk({tag, "_in_valid"}, 64'(bus.C_in_valid), 64'd0);
      chk({tag, "_c_addr"},   64'(bus.C_addr), 64'd0);
      chk({tag, "_c_data_w"}, bus.C_data_w, 64'd0);
      chk({tag, "_c_r_wb"},   64'(bus.C_r_wb), 64'd0);
      chk({tag, "_done"},     64'({bus.rq0_done, bus.rq1_done}), 64'd0);
      chk({tag, "_err"},      64'({bus.rq0_err, bus.rq1_err}), 64'd0);
      chk({tag, "_rdata0"},   bus.rq0_rdata, 64'd0);
      chk({tag, "_rdata1"},   bus.rq1_rdata, 64'd0);
   endtask

   task automatic model_reset();
      m_last = 1;
      m_rdata[0] = '0; m_rdata[1] = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0;
      bus.C_out_valid = 1'b0; bus.C_data_r = '0;
      set_req(0, 8'h00, 64'h0, 1'b0);
      set_req(1, 8'h00, 64'h0, 1'b0);
      step(); step();
      rst_n = 1'b1;
      model_reset();
   endtask

   // Starts at an IDLE-cycle negedge, ends at the IDLE negedge after DONE.
   // dly >= 0: bridge answers in the (dly)th WAIT cycle; dly < 0: never.
   task automatic run_txn(input logic v0, input logic v1, input int dly,
                          input logic [63:0] rsp, input int id);
      int   lat;
      int   k;
      logic tmo;
      tmo = (dly < 0);
      bus.rq0_valid = v0;
      bus.rq1_valid = v1;
      lat = 0;
      do begin step(); lat++; end while (!bus.C_in_valid && lat < 8);
      chk("issue_latency", 64'(lat), 64'd1);
      chk("issue_addr",  64'(bus.C_addr), 64'(m_addr[id]));
      chk("issue_wdata", bus.C_data_w, m_wdata[id]);
      chk("issue_r_wb",  64'(bus.C_r_wb), 64'(m_rw[id]));
      m_last = id;
      step();
      chk("issue_one_pulse", 64'(bus.C_in_valid), 64'd0);
      k = 0;
      while (k < 1100 && !bus.rq0_done && !bus.rq1_done) begin
         if (k == dly) begin bus.C_out_valid = 1'b1; bus.C_data_r = rsp; end
         step();
         bus.C_out_valid = 1'b0;
         bus.C_data_r = {$urandom, $urandom};
         k++;
      end
      chk("wait_cycles", 64'(k), tmo ? 64'(TMO) : 64'(dly + 1));
      if (tmo)            m_rdata[id] = '0;
      else if (m_rw[id])  m_rdata[id] = rsp;
      chk("done0",  64'(bus.rq0_done), 64'(id == 0));
      chk("done1",  64'(bus.rq1_done), 64'(id == 1));
      chk("err0",   64'(bus.rq0_err), 64'(id == 0 && tmo));
      chk("err1",   64'(bus.rq1_err), 64'(id == 1 && tmo));
      chk("rdata0", bus.rq0_rdata, m_rdata[0]);
      chk("rdata1", bus.rq1_rdata, m_rdata[1]);
      chk("done_addr_stable", 64'(bus.C_addr), 64'(m_addr[id]));
      chk("done_busy", 64'(busy), 64'd1);
      if (id == 0) bus.rq0_valid = 1'b0;
      else         bus.rq1_valid = 1'b0;
      step();
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_no_done", 64'({bus.rq0_done, bus.rq1_done}), 64'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int id;
      int r0;

      tbl[0] = '{1'b1, 1'b0, 8'h2A, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0, 2, 64'hDEAD_BEEF_0123_4567, 0};
      tbl[1] = '{1'b1, 1'b1, 8'h05, 8'h06, 64'h1, 64'h0, 1'b0, 1'b1, 0, 64'h1111_2222_3333_4444, 1};
      tbl[2] = '{1'b1, 1'b1, 8'h05, 8'h07, 64'h1, 64'h0, 1'b0, 1'b1, 4, 64'hAAAA_AAAA_AAAA_AAAA, 0};
      tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h07, 64'h0, 64'h0, 1'b0, 1'b1, 1, 64'h5555_6666_7777_8888, 1};
      tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h44, 64'h0, 64'hCAFE, 1'b0, 1'b0, 0, 64'h9999_9999_9999_9999, 1};
      tbl[5] = '{1'b1, 1'b1, 8'h10, 8'h11, 64'h0, 64'h0, 1'b1, 1'b1, 3, 64'h0123_4567_89AB_CDEF, 0};
      tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h11, 64'h0, 64'h0, 1'b0, 1'b1, 5, 64'h7777_7777_0000_0001, 1};
      tbl[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0, 2, 64'hBBBB_0000_BBBB_0000, 0};

      do_reset();
      chk_all_zero("reset");

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].v0) set_req(0, tbl[i].a0, tbl[i].w0, tbl[i].rw0);
         if (tbl[i].v1) set_req(1, tbl[i].a1, tbl[i].w1, tbl[i].rw1);
         run_txn(tbl[i].v0, tbl[i].v1, tbl[i].dly, tbl[i].rsp, tbl[i].exp_id);
      end

      // both requesters continuously valid from reset: strict alternation
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            set_req(0, 8'h05, 64'h1, 1'b0);
            set_req(1, 8'h06, 64'h0, 1'b1);
         end else begin
            set_req((i - 1) % 2, 8'(8'h20 + i), 64'(i * 3 + 1), 1'($urandom));
         end
         run_txn(1'b1, 1'b1, i + 1, {$urandom, $urandom}, i % 2);
      end

      // randomized traffic; pending requests stay asserted and unchanged
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int n = 0; n < 24; n++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               set_req(r, 8'($urandom), {$urandom, $urandom}, 1'($urandom));
               pend[r] = 1'b1;
            end
         end
         if (!pend[0] && !pend[1]) begin
            r0 = $urandom_range(0, 1);
            set_req(r0, 8'($urandom), {$urandom, $urandom}, 1'($urandom));
            pend[r0] = 1'b1;
         end
         id = ref_pick(pend[0], pend[1]);
         run_txn(pend[0], pend[1], $urandom_range(0, 6), {$urandom, $urandom}, id);
         pend[id] = 1'b0;
      end

      // completion on the timeout cycle itself wins over the abort
      set_req(1, 8'h3C, 64'h0, 1'b1);
      run_txn(1'b0, 1'b1, TMO - 1, 64'hFACE_0000_1234_5678, 1);

      // bridge never answers: abort with err and cleared rdata
      set_req(0, 8'h2A, 64'h0, 1'b1);
      run_txn(1'b1, 1'b0, 1, 64'h0BAD_F00D_0BAD_F00D, 0);
      set_req(0, 8'h2B, 64'h0, 1'b1);
      run_txn(1'b1, 1'b0, -1, 64'h0, 0);

      // a late completion after the abort must not produce a done
      repeat (4) step();
      bus.C_out_valid = 1'b1; bus.C_data_r = 64'h1357_9BDF_2468_ACE0;
      step();
      bus.C_out_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_rsp_done", 64'({bus.rq0_done, bus.rq1_done}), 64'd0);
         chk("late_rsp_busy", 64'(busy), 64'd0);
         step();
      end
      chk("late_rsp_rdata0", bus.rq0_rdata, 64'd0);

      // reset in the middle of WAIT
      set_req(1, 8'h77, 64'h0, 1'b1);
      bus.rq1_valid = 1'b1;
      step(); step(); step(); step();
      chk("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      bus.rq1_valid = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      chk_all_zero("mid_reset");
      bus.C_out_valid = 1'b1; bus.C_data_r = 64'hFFFF_0000_FFFF_0000;
      step();
      bus.C_out_valid = 1'b0;
      chk("stray_rsp_done", 64'({bus.rq0_done, bus.rq1_done}), 64'd0);
      chk("stray_rsp_busy", 64'(busy), 64'd0);
      step();
      chk("stray_rsp_rdata1", bus.rq1_rdata, 64'd0);
      set_req(0, 8'h12, 64'h0, 1'b1);
      set_req(1, 8'h34, 64'h0, 1'b1);
      run_txn(1'b1, 1'b1, 2, 64'h4242_4242_4242_4242, 0);
      run_txn(1'b0, 1'b1, 0, 64'h2424_2424_2424_2424, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/c_port_arbiter.md
Name: c_port_arbiter

Overview:
- Shares the single bridge-side C_* port (C_addr/C_data_w/C_in_valid/C_r_wb and C_out_valid/C_data_r) between two requesters.
  - Requester 0: pokemon main controller (player fetch / write-back).
  - Requester 1: seller/opponent prefetch engine.
- One outstanding bridge transaction at a time, round-robin between requesters.
- A watchdog timeout stops a hung DRAM transaction from stalling the controller forever.
- Sits between the pokemon_inf-side logic and the bridge_inf instance.

Parameters:
- TIMEOUT_CYC, 1023: cycles waited in WAIT for C_out_valid before aborting the transaction with an error.
- CNT_W, 10: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- rq0_valid  in  1  level request from requester 0; held high until rq0_done
- rq0_addr  in  8  player/entry ID (DRAM slot)
- rq0_wdata  in  64  write data
- rq0_r_wb  in  1  1 = read, 0 = write
- rq0_done  out  1  one-cycle completion pulse
- rq0_err  out  1  valid with rq0_done; 1 = timeout abort
- rq0_rdata  out  64  read data, held until the next rq0 read completes
- rq1_valid, rq1_addr, rq1_wdata, rq1_r_wb, rq1_done, rq1_err, rq1_rdata: same as rq0_*, for requester 1
- C_in_valid  out  1  one-cycle command pulse to the bridge
- C_addr  out  8  command address
- C_data_w  out  64  command write data
- C_r_wb  out  1  command direction
- C_out_valid  in  1  one-cycle bridge completion pulse
- C_data_r  in  64  bridge read data, valid with C_out_valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (sync, rst_n = 0 at a clk edge):
  - State IDLE, last_gnt = 1, watchdog counter = 0.
  - All outputs 0, including both rdata buses.
  - A reset during ISSUE or WAIT abandons the in-flight transaction; any later stray C_out_valid in IDLE is ignored.
- State machine, states IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any rqN_valid is high, pick a winner, register gnt, addr, wdata and r_wb from the winner, then go to ISSUE.
  - Pick rule when only one requester is valid: that requester wins.
  - Pick rule when both are valid: the requester != last_gnt wins.
  - last_gnt updates on the grant.
  - C_out_valid is ignored in IDLE.
- ISSUE:
  - C_in_valid = 1 for exactly this one cycle, with C_addr, C_data_w and C_r_wb driven from the registered values.
  - Go to WAIT and clear the counter.
  - C_addr, C_data_w and C_r_wb stay stable from ISSUE through DONE.
- WAIT:
  - Counter increments every cycle.
  - If C_out_valid = 1: capture C_data_r into the granted rqN_rdata only if r_wb = 1 (writes leave rdata unchanged); err = 0; go to DONE.
  - Else, if counter == TIMEOUT_CYC - 1: err = 1, rdata of the granted requester = 0, go to DONE.
  - If C_out_valid arrives on the same cycle as the timeout, C_out_valid wins and err = 0.
- DONE:
  - rqN_done = 1 (and rqN_err) for the granted requester only, for exactly one cycle.
  - Go to IDLE.
- Latency:
  - Request sampled in IDLE at edge t gives C_in_valid during cycle t+1.
  - Bridge completion in cycle k gives rqN_done in cycle k+1.
  - Minimum done-to-next-issue gap: 2 cycles (DONE, IDLE).
- Requester contract:
  - A requester deasserts rqN_valid in the cycle after it sees done.
  - IDLE samples one cycle after DONE, so a requester's finished request is never re-granted.
  - A requester must not change addr/wdata/r_wb while its valid is high; the arbiter's register holds them anyway.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- No ordering guarantee between the two requesters other than grant order; same-address read/write hazards are resolved by grant order.

Decomposition:
- Additions to the shared usertype package:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} Arb_State.
  - localparam ARB_TIMEOUT_DEF = 1023.
- Sub-module rr_pick2 (combinational 2-way round-robin chooser).
  - Inputs: req[1:0], last_gnt.
  - Outputs: gnt_id, any.
  - Reused later by the checker model.

Test Plan:
1. Only rq0 read at addr 8'h2A; bridge returns 64'hDEAD_BEEF_0123_4567 three cycles after C_in_valid -> single C_in_valid pulse with C_addr = 2A, C_r_wb = 1; rq0_done one cycle after C_out_valid; rq0_rdata = DEADBEEF01234567; rq0_err = 0; rq1_done stays 0.
2. Both requesters valid from reset: rq0 write addr 05 data 64'h1, rq1 read addr 06 -> rq0 granted first (C_r_wb = 0, C_data_w = 1), then rq1; rq0_rdata unchanged (0); 2-cycle gap between rq0_done and the second C_in_valid.
3. Both requesters continuously re-requesting for 6 transactions -> grant order 0,1,0,1,0,1.
4. Bridge never responds, TIMEOUT_CYC = 1023 -> rq_done with rq_err = 1 exactly 1023 cycles after entering WAIT; rdata = 0. A C_out_valid pulse 5 cycles later produces no done.
5. C_out_valid on the timeout cycle -> err = 0 and data captured.
6. rst_n low for one edge during WAIT -> next cycle: busy = 0, all outputs 0. The late C_out_valid is ignored, and a new rq1 request is served normally with rq1 winning a tie against rq0? No: after reset last_gnt = 1, so rq0 wins a tie.
